// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory stage: funct3 encodings, FSM states
// and the store byte-enable helper.
package riscv_mem_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  // size is funct3[1:0]: 00 byte, 01 half, 10 word
  function automatic logic [3:0] wstrb_for(input logic [1:0] size,
                                           input logic [1:0] offset);
    case (size)
      2'b00:   return 4'b0001 << offset;
      2'b01:   return 4'b0011 << offset;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load alignment: shifts the addressed byte/half down to lane 0 and applies
// sign or zero extension according to funct3.
module mem_load_align
  import riscv_mem_pkg::*;
(
  input  logic [31:0] rsp_data,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rsp_data >> {offset, 3'b000};
    case (funct3)
      LB:      load_data = {{24{shifted[7]}}, shifted[7:0]};
      LBU:     load_data = {24'h0, shifted[7:0]};
      LH:      load_data = {{16{shifted[15]}}, shifted[15:0]};
      LHU:     load_data = {16'h0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// RISC-V memory stage: issues data-memory requests from EX/MEM, stalls the
// pipeline until completion and reports illegal/error/timeout faults.
module mem_access_unit
  import riscv_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [2:0]  Funct3_in,
  input  logic [31:0] ALUResult_in,
  input  logic [31:0] WriteData_in,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rsp_data,
  input  logic        dmem_rsp_err,
  output logic [31:0] ReadData_out,
  output logic        Stall_out,
  output logic        Fault_out,
  output logic [31:0] FaultAddr_out
);

  mem_state_t      state;
  logic [TO_W-1:0] to_cnt;
  logic [31:0]     addr_q;
  logic [2:0]      f3_q;
  logic            we_q;
  logic [31:0]     wdata_q;
  logic [3:0]      wstrb_q;
  logic [31:0]     read_data_q;
  logic            fault_q;
  logic [31:0]     fault_addr_q;

  logic            access;
  logic            illegal;
  logic            misaligned;
  logic [31:0]     req_wdata;
  logic [3:0]      req_wstrb;
  logic [31:0]     load_data;

  mem_load_align u_align (
    .rsp_data  (dmem_rsp_data),
    .offset    (addr_q[1:0]),
    .funct3    (f3_q),
    .load_data (load_data)
  );

  always_comb begin
    access     = MemRead_in | MemWrite_in;
    misaligned = ((Funct3_in[1:0] == 2'b01) && ALUResult_in[0]) ||
                 ((Funct3_in[1:0] == 2'b10) && (ALUResult_in[1:0] != 2'b00));
    illegal    = (MemRead_in && MemWrite_in) ||
                 (MemRead_in && !(Funct3_in inside {LB, LH, LW, LBU, LHU})) ||
                 (MemWrite_in && !(Funct3_in inside {SB, SH, SW})) ||
                 misaligned;
    req_wdata  = '0;
    req_wstrb  = '0;
    if (MemWrite_in) begin
      req_wstrb = wstrb_for(Funct3_in[1:0], ALUResult_in[1:0]);
      case (Funct3_in[1:0])
        2'b00:   req_wdata = {4{WriteData_in[7:0]}};
        2'b01:   req_wdata = {2{WriteData_in[15:0]}};
        default: req_wdata = WriteData_in;
      endcase
    end
  end

  // IDLE presents the request straight from EX/MEM; REQ replays the latched copy
  always_comb begin
    Stall_out      = 1'b0;
    dmem_req_valid = 1'b0;
    dmem_we        = 1'b0;
    dmem_addr      = '0;
    dmem_wdata     = '0;
    dmem_wstrb     = '0;
    if (reset) begin
      unique case (state)
        IDLE: if (access) begin
          Stall_out = 1'b1;
          if (!illegal) begin
            dmem_req_valid = 1'b1;
            dmem_we        = MemWrite_in;
            dmem_addr      = {ALUResult_in[31:2], 2'b00};
            dmem_wdata     = req_wdata;
            dmem_wstrb     = req_wstrb;
          end
        end
        REQ: begin
          Stall_out      = 1'b1;
          dmem_req_valid = 1'b1;
          dmem_we        = we_q;
          dmem_addr      = {addr_q[31:2], 2'b00};
          dmem_wdata     = wdata_q;
          dmem_wstrb     = wstrb_q;
        end
        WAIT: Stall_out = 1'b1;
        DONE: Stall_out = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      to_cnt       <= '0;
      addr_q       <= '0;
      f3_q         <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      read_data_q  <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      unique case (state)
        IDLE: if (access) begin
          if (illegal) begin
            fault_q      <= 1'b1;
            fault_addr_q <= ALUResult_in;
            if (MemRead_in) read_data_q <= '0;
            state        <= DONE;
          end else begin
            addr_q  <= ALUResult_in;
            f3_q    <= Funct3_in;
            we_q    <= MemWrite_in;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            if (dmem_req_ready) state <= MemWrite_in ? DONE : WAIT;
            else                state <= REQ;
          end
        end
        REQ: if (dmem_req_ready) state <= we_q ? DONE : WAIT;
        WAIT: begin
          if (dmem_rsp_valid) begin
            to_cnt <= '0;
            state  <= DONE;
            if (dmem_rsp_err) begin
              fault_q      <= 1'b1;
              fault_addr_q <= addr_q;
              read_data_q  <= '0;
            end else begin
              read_data_q <= load_data;
            end
          end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            to_cnt       <= '0;
            state        <= DONE;
            fault_q      <= 1'b1;
            fault_addr_q <= addr_q;
            read_data_q  <= '0;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        DONE: begin
          fault_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign ReadData_out  = read_data_q;
  assign Fault_out     = fault_q;
  assign FaultAddr_out = fault_addr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected completions are queued as
// each access is driven and compared when the unit reaches DONE.
module tb_mem_access_unit;

  localparam int unsigned TO = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        MemRead_in = 1'b0, MemWrite_in = 1'b0;
  logic [2:0]  Funct3_in = '0;
  logic [31:0] ALUResult_in = '0, WriteData_in = '0;
  logic        dmem_req_valid, dmem_req_ready = 1'b0, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_rsp_valid = 1'b0, dmem_rsp_err = 1'b0;
  logic [31:0] dmem_rsp_data = '0;
  logic [31:0] ReadData_out, FaultAddr_out;
  logic        Stall_out, Fault_out;

  always #5 clock = ~clock;

  mem_access_unit #(.TIMEOUT(TO), .TO_W(8)) dut (
    .clock(clock), .reset(reset),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .Funct3_in(Funct3_in),
    .ALUResult_in(ALUResult_in), .WriteData_in(WriteData_in),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_rsp_valid(dmem_rsp_valid),
    .dmem_rsp_data(dmem_rsp_data), .dmem_rsp_err(dmem_rsp_err),
    .ReadData_out(ReadData_out), .Stall_out(Stall_out),
    .Fault_out(Fault_out), .FaultAddr_out(FaultAddr_out)
  );

  typedef struct {
    logic [31:0] rdata;
    bit          chk_rdata;
    logic        fault;
    logic [31:0] faddr;
    int          stalls;
    int          reqs;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] last_rdata = '0;

  bit          obs_done, obs_stable, obs_we, obs_fault;
  int          obs_stalls, obs_reqs;
  logic [31:0] obs_addr, obs_wdata, obs_rdata, obs_faddr;
  logic [3:0]  obs_wstrb;

  function automatic logic [31:0] ref_load(input logic [31:0] w, input int off,
                                           input logic [2:0] f3);
    logic [63:0] ww;
    logic [7:0]  b;
    logic [15:0] h;
    ww = {32'h0, w};
    b  = ww[8*off +: 8];
    h  = ww[8*off +: 16];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] ref_strb(input int nbytes, input int off);
    logic [3:0] s;
    for (int i = 0; i < 4; i++) s[i] = (i >= off) && (i < off + nbytes);
    return s;
  endfunction

  function automatic logic [31:0] ref_wdata(input int nbytes, input logic [31:0] wd);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nbytes) +: 8];
    return r;
  endfunction

  // Plays EX/MEM and the memory for one access; records what the unit did.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input int ready_wait, input int rsp_wait,
                            input logic [31:0] word, input logic err);
    int n_req = 0;
    int wait_idx = 0;
    bit waiting = 0;
    obs_done = 0; obs_stalls = 0; obs_stable = 1; obs_we = 0;
    obs_addr = '0; obs_wdata = '0; obs_wstrb = '0;
    @(negedge clock);
    MemRead_in = rd; MemWrite_in = wr; Funct3_in = f3;
    ALUResult_in = addr; WriteData_in = wd;
    for (int c = 0; c < 300; c++) begin
      dmem_req_ready = (n_req >= ready_wait);
      dmem_rsp_valid = waiting && (rsp_wait >= 0) && (wait_idx == rsp_wait);
      dmem_rsp_data  = word;
      dmem_rsp_err   = err;
      if (waiting) wait_idx++;
      #1;
      if (!Stall_out) begin
        obs_done  = 1;
        obs_rdata = ReadData_out;
        obs_fault = Fault_out;
        obs_faddr = FaultAddr_out;
        break;
      end
      obs_stalls++;
      if (dmem_req_valid) begin
        if (n_req == 0) begin
          obs_addr = dmem_addr; obs_wdata = dmem_wdata;
          obs_wstrb = dmem_wstrb; obs_we = dmem_we;
        end else if (dmem_addr !== obs_addr || dmem_wdata !== obs_wdata ||
                     dmem_wstrb !== obs_wstrb || dmem_we !== obs_we) begin
          obs_stable = 0;
        end
        n_req++;
        if (dmem_req_ready && rd && !wr) waiting = 1;
      end
      @(negedge clock);
    end
    obs_reqs = n_req;
    MemRead_in = 0; MemWrite_in = 0;
    dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rsp_err = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    MemRead_in = 1'b1; Funct3_in = 3'b010; ALUResult_in = 32'h100; dmem_req_ready = 1'b1;
    @(negedge clock); #1;
    total++;
    if ({Stall_out, dmem_req_valid, dmem_we} !== 3'b000) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=000", {Stall_out, dmem_req_valid, dmem_we});
    end
    total++;
    if (dmem_addr !== 32'h0 || dmem_wdata !== 32'h0 || dmem_wstrb !== 4'h0) begin
      bad++; $display("FAIL reset_bus got addr=%h wdata=%h wstrb=%b exp=0", dmem_addr, dmem_wdata, dmem_wstrb);
    end
    total++;
    if (ReadData_out !== 32'h0 || Fault_out !== 1'b0 || FaultAddr_out !== 32'h0) begin
      bad++; $display("FAIL reset_regs got rd=%h f=%b fa=%h exp=0", ReadData_out, Fault_out, FaultAddr_out);
    end
    MemRead_in = 1'b0; dmem_req_ready = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_load_zero_wait();
    exp_t e;
    sb.push_back('{32'hDEADBEEF, 1, 1'b0, 32'h0, 2, 1});
    run_access(1, 0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 0);
    last_rdata = 32'hDEADBEEF;
    e = sb.pop_front();
    total++;
    if (!obs_done || obs_stalls != e.stalls) begin
      bad++; $display("FAIL lw_latency got done=%0d stalls=%0d exp stalls=%0d", obs_done, obs_stalls, e.stalls);
    end
    total++;
    if (obs_rdata !== e.rdata || obs_fault !== e.fault) begin
      bad++; $display("FAIL lw_data got=%h f=%b exp=%h f=%b", obs_rdata, obs_fault, e.rdata, e.fault);
    end
    total++;
    if (obs_addr !== 32'h100 || obs_we !== 1'b0 || obs_wstrb !== 4'b0000) begin
      bad++; $display("FAIL lw_req got addr=%h we=%b wstrb=%b exp 100/0/0000", obs_addr, obs_we, obs_wstrb);
    end
  endtask

  task automatic test_byte_loads();
    exp_t e;
    sb.push_back('{32'hFFFFFF80, 1, 1'b0, 32'h0, 2, 1});
    sb.push_back('{32'h00000080, 1, 1'b0, 32'h0, 2, 1});
    for (int k = 0; k < 2; k++) begin
      run_access(1, 0, (k == 0) ? 3'b000 : 3'b100, 32'h103, 32'h0, 0, 0, 32'h80FF1234, 0);
      e = sb.pop_front();
      last_rdata = e.rdata;
      total++;
      if (!obs_done || obs_rdata !== e.rdata || obs_fault !== 1'b0) begin
        bad++; $display("FAIL byte_load%0d got=%h f=%b exp=%h", k, obs_rdata, obs_fault, e.rdata);
      end
    end
  endtask

  task automatic test_store_backpressure();
    exp_t e;
    sb.push_back('{last_rdata, 1, 1'b0, 32'h0, 4, 4});
    run_access(0, 1, 3'b001, 32'h102, 32'h0000ABCD, 3, -1, 32'h0, 0);
    e = sb.pop_front();
    total++;
    if (obs_reqs != e.reqs || obs_stalls != e.stalls || !obs_done) begin
      bad++; $display("FAIL sh_hold got reqs=%0d stalls=%0d exp=%0d/%0d", obs_reqs, obs_stalls, e.reqs, e.stalls);
    end
    total++;
    if (obs_wstrb !== 4'b1100 || obs_wdata !== 32'hABCDABCD || obs_addr !== 32'h100 || obs_we !== 1'b1) begin
      bad++; $display("FAIL sh_bus got wstrb=%b wdata=%h addr=%h we=%b exp 1100/abcdabcd/100/1",
                      obs_wstrb, obs_wdata, obs_addr, obs_we);
    end
    total++;
    if (!obs_stable) begin
      bad++; $display("FAIL sh_stable got=0 exp=1");
    end
    total++;
    if (obs_rdata !== e.rdata || obs_fault !== 1'b0) begin
      bad++; $display("FAIL sh_done got rd=%h f=%b exp rd=%h f=0", obs_rdata, obs_fault, e.rdata);
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    logic rd_v[3]  = '{1'b1, 1'b1, 1'b1};
    logic wr_v[3]  = '{1'b0, 1'b1, 1'b0};
    logic [2:0]  f3_v[3] = '{3'b010, 3'b000, 3'b011};
    logic [31:0] ad_v[3] = '{32'h101, 32'h200, 32'h300};
    sb.push_back('{32'h0, 1, 1'b1, 32'h101, 1, 0});
    sb.push_back('{32'h0, 0, 1'b1, 32'h200, 1, 0});
    sb.push_back('{32'h0, 1, 1'b1, 32'h300, 1, 0});
    for (int k = 0; k < 3; k++) begin
      run_access(rd_v[k], wr_v[k], f3_v[k], ad_v[k], 32'h55, 0, 0, 32'h12345678, 0);
      e = sb.pop_front();
      total++;
      if (!obs_done || obs_fault !== e.fault || obs_faddr !== e.faddr) begin
        bad++; $display("FAIL illegal%0d got f=%b fa=%h exp f=%b fa=%h", k, obs_fault, obs_faddr, e.fault, e.faddr);
      end
      total++;
      if (obs_reqs != e.reqs || obs_stalls != e.stalls) begin
        bad++; $display("FAIL illegal%0d_noreq got reqs=%0d stalls=%0d exp=%0d/%0d", k, obs_reqs, obs_stalls, e.reqs, e.stalls);
      end
      if (e.chk_rdata) begin
        total++;
        if (obs_rdata !== e.rdata) begin
          bad++; $display("FAIL illegal%0d_rdata got=%h exp=%h", k, obs_rdata, e.rdata);
        end
      end
      @(negedge clock); #1;
      total++;
      if (Fault_out !== 1'b0) begin
        bad++; $display("FAIL illegal%0d_pulse got=%b exp=0", k, Fault_out);
      end
    end
  endtask

  task automatic test_timeout_and_error();
    exp_t e;
    sb.push_back('{32'h00008001, 1, 1'b0, 32'h0, 2, 1});
    sb.push_back('{32'h0, 1, 1'b1, 32'h40, TO + 1, 1});
    sb.push_back('{32'hFFFFF00F, 1, 1'b0, 32'h0, 2, 1});
    sb.push_back('{32'h0, 1, 1'b1, 32'h50, 2, 1});
    run_access(1, 0, 3'b101, 32'h46, 32'h0, 0, 0, 32'h80010000, 0);
    e = sb.pop_front();
    total++;
    if (obs_rdata !== e.rdata) begin
      bad++; $display("FAIL lhu got=%h exp=%h", obs_rdata, e.rdata);
    end
    run_access(1, 0, 3'b010, 32'h40, 32'h0, 0, -1, 32'h0, 0);
    e = sb.pop_front();
    total++;
    if (!obs_done || obs_stalls != e.stalls || obs_fault !== 1'b1) begin
      bad++; $display("FAIL timeout got done=%0d stalls=%0d f=%b exp stalls=%0d f=1", obs_done, obs_stalls, obs_fault, e.stalls);
    end
    total++;
    if (obs_rdata !== e.rdata || obs_faddr !== e.faddr) begin
      bad++; $display("FAIL timeout_regs got rd=%h fa=%h exp rd=%h fa=%h", obs_rdata, obs_faddr, e.rdata, e.faddr);
    end
    run_access(1, 0, 3'b001, 32'h52, 32'h0, 0, 1, 32'hF00F0000, 0);
    e = sb.pop_front();
    total++;
    if (obs_rdata !== e.rdata || obs_stalls != 3) begin
      bad++; $display("FAIL lh got=%h stalls=%0d exp=%h stalls=3", obs_rdata, obs_stalls, e.rdata);
    end
    run_access(1, 0, 3'b010, 32'h50, 32'h0, 0, 0, 32'h77777777, 1);
    e = sb.pop_front();
    total++;
    if (obs_fault !== 1'b1 || obs_rdata !== e.rdata || obs_faddr !== e.faddr || obs_stalls != e.stalls) begin
      bad++; $display("FAIL rsp_err got f=%b rd=%h fa=%h stalls=%0d exp f=1 rd=%h fa=%h stalls=%0d",
                      obs_fault, obs_rdata, obs_faddr, obs_stalls, e.rdata, e.faddr, e.stalls);
    end
    last_rdata = 32'h0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [2:0] lf3[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int i = 0; i < 16; i++) begin
      bit          is_ld;
      logic [2:0]  f3;
      int          nb, off, rw, sw;
      logic [31:0] addr, wd, word;
      is_ld = 1'($urandom_range(0, 1));
      f3    = is_ld ? lf3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      nb    = 1 << f3[1:0];
      off   = (nb == 1) ? $urandom_range(0, 3) : (nb == 2) ? 2 * $urandom_range(0, 1) : 0;
      addr  = ($urandom & 32'hFFFF_FFFC) | 32'(off);
      wd    = $urandom;
      word  = $urandom;
      rw    = $urandom_range(0, 2);
      sw    = $urandom_range(0, 2);
      if (is_ld) last_rdata = ref_load(word, off, f3);
      sb.push_back('{last_rdata, 1, 1'b0, 32'h0, is_ld ? rw + sw + 2 : rw + 1, rw + 1});
      run_access(is_ld, !is_ld, f3, addr, wd, rw, sw, word, 0);
      e = sb.pop_front();
      total++;
      if (!obs_done || obs_rdata !== e.rdata || obs_fault !== 1'b0 || obs_stalls != e.stalls) begin
        bad++; $display("FAIL b2b%0d got rd=%h f=%b stalls=%0d exp rd=%h f=0 stalls=%0d",
                        i, obs_rdata, obs_fault, obs_stalls, e.rdata, e.stalls);
      end
      total++;
      if (obs_addr !== {addr[31:2], 2'b00} || obs_reqs != e.reqs || !obs_stable ||
          obs_wstrb !== (is_ld ? 4'b0000 : ref_strb(nb, off)) ||
          (!is_ld && obs_wdata !== ref_wdata(nb, wd))) begin
        bad++; $display("FAIL b2b%0d_req got addr=%h wstrb=%b wdata=%h reqs=%0d exp addr=%h wstrb=%b wdata=%h reqs=%0d",
                        i, obs_addr, obs_wstrb, obs_wdata, obs_reqs, {addr[31:2], 2'b00},
                        is_ld ? 4'b0000 : ref_strb(nb, off), ref_wdata(nb, wd), e.reqs);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    run_access(1, 0, 3'b010, 32'h60, 32'h0, 0, 0, 32'h12345678, 0);
    total++;
    if (obs_rdata !== 32'h12345678) begin
      bad++; $display("FAIL pre_reset_lw got=%h exp=12345678", obs_rdata);
    end
    @(negedge clock);
    MemRead_in = 1; Funct3_in = 3'b010; ALUResult_in = 32'h80; dmem_req_ready = 1;
    @(negedge clock); #1;
    total++;
    if (Stall_out !== 1'b1 || dmem_req_valid !== 1'b0) begin
      bad++; $display("FAIL wait_state got stall=%b req=%b exp 1/0", Stall_out, dmem_req_valid);
    end
    reset = 1'b0; MemRead_in = 0; dmem_req_ready = 0;
    #1;
    total++;
    if (Stall_out !== 1'b0 || ReadData_out !== 32'h0 || Fault_out !== 1'b0 || FaultAddr_out !== 32'h0) begin
      bad++; $display("FAIL async_reset got stall=%b rd=%h f=%b fa=%h exp all 0", Stall_out, ReadData_out, Fault_out, FaultAddr_out);
    end
    @(negedge clock); reset = 1'b1;
    @(negedge clock); dmem_rsp_valid = 1; dmem_rsp_data = 32'hCAFEF00D;
    @(negedge clock); dmem_rsp_valid = 0;
    for (int k = 0; k < 2; k++) begin
      #1;
      total++;
      if (Stall_out !== 1'b0 || ReadData_out !== 32'h0 || Fault_out !== 1'b0) begin
        bad++; $display("FAIL late_rsp%0d got stall=%b rd=%h f=%b exp 0/0/0", k, Stall_out, ReadData_out, Fault_out);
      end
      @(negedge clock);
    end
    sb.push_back('{32'h0BADF00D, 1, 1'b0, 32'h0, 2, 1});
    run_access(1, 0, 3'b010, 32'h70, 32'h0, 0, 0, 32'h0BADF00D, 0);
    e = sb.pop_front();
    total++;
    if (!obs_done || obs_rdata !== e.rdata || obs_fault !== 1'b0 || obs_stalls != e.stalls) begin
      bad++; $display("FAIL post_reset_lw got rd=%h f=%b stalls=%0d exp rd=%h f=0 stalls=%0d",
                      obs_rdata, obs_fault, obs_stalls, e.rdata, e.stalls);
    end
  endtask

  initial begin
    test_reset();
    test_load_zero_wait();
    test_byte_loads();
    test_store_backpressure();
    test_illegal();
    test_timeout_and_error();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory stage of the RISC-V pipeline, directly downstream of the EX/MEM pipeline register.
- Consumes that register's address (ALU result), store data and memory controls, and runs the data-memory transaction over a valid/ready request and response interface.
- Performs byte/half/word store lane steering and load alignment with sign or zero extension.
- Stalls the pipeline until the access completes, and reports faults for misaligned or illegal accesses, error responses and timeouts.

Parameters:
- TIMEOUT, 255: maximum cycles spent in WAIT before a timeout fault is raised.
- TO_W, 8: width of the timeout counter; must hold TIMEOUT.

Ports:
- clock  in  1  pipeline clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- MemRead_in  in  1  load request from EX/MEM
- MemWrite_in  in  1  store request from EX/MEM
- Funct3_in  in  3  access size and signedness
- ALUResult_in  in  32  byte address
- WriteData_in  in  32  store data, lane 0 aligned
- dmem_req_valid  out  1  request valid
- dmem_req_ready  in  1  memory accepts request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address ({ALUResult_in[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_wstrb  out  4  byte enables
- dmem_rsp_valid  in  1  response valid (loads only)
- dmem_rsp_data  in  32  response word
- dmem_rsp_err  in  1  response error, qualified by rsp_valid
- ReadData_out  out  32  extended load result
- Stall_out  out  1  hold PC, IF/ID, ID/EX and EX/MEM
- Fault_out  out  1  one-cycle fault pulse
- FaultAddr_out  out  32  address of the faulting access

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE and the timeout counter clears.
  - ReadData_out, Fault_out and FaultAddr_out are 0.
  - Stall_out, dmem_req_valid and dmem_we are forced to 0; dmem_addr, dmem_wdata and dmem_wstrb are 0.
  - Reset mid-transaction abandons it; any late response arriving in IDLE is ignored.
- Access is MemRead_in|MemWrite_in.
- An access is illegal when any of these hold:
  - both MemRead_in and MemWrite_in are set;
  - load funct3 is not in {000,001,010,100,101};
  - store funct3 is not in {000,001,010};
  - the access is misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
- FSM states are IDLE, REQ, WAIT, DONE.
- IDLE:
  - No access: stay in IDLE, Stall=0.
  - Illegal access: no request is issued, FaultAddr latches the address, go to DONE with a fault pending, Stall=1.
  - Legal access: dmem_req_valid=1 combinationally and Stall=1.
    - ready=1: a store goes to DONE; a load goes to WAIT.
    - ready=0: go to REQ.
- REQ: req_valid=1 with address, data and strobe held stable; Stall=1. On ready, branch to DONE or WAIT as in IDLE.
- WAIT: Stall=1 and the counter increments each cycle.
  - rsp_valid: capture the extended data, or flag a fault if rsp_err; go to DONE.
  - Counter reaches TIMEOUT: fault; go to DONE.
  - rsp_valid wins over timeout in the same cycle.
- DONE: lasts one cycle with Stall=0, so EX/MEM advances. Then go to IDLE.
  - ReadData_out updates on DONE entry: the extended value for a successful load, 0 for a faulting load. It is unchanged for stores and holds between DONE entries.
  - Fault_out is 1 during DONE only.
- Load offset addr[1:0] and funct3 are latched at request acceptance.
- Load extraction: selected byte = rsp_data >> (8*offset).
  - LB: sign-extend bits [7:0]; LBU: zero-extend them.
  - LH: sign-extend bits [15:0]; LHU: zero-extend them.
  - LW: full word.
- Store encoding:
  - SB: wstrb = 0001 << offset, wdata = {4{WriteData_in[7:0]}}.
  - SH: wstrb = 0011 << offset, wdata = {2{WriteData_in[15:0]}}.
  - SW: wstrb = 1111, wdata = WriteData_in.
  - Loads drive wstrb = 0000.
- Minimum latency with zero-wait memory (response the cycle after acceptance):
  - Load: 3 cycles (stall, stall, DONE).
  - Store: 2 cycles (stall, DONE).

Decomposition:
- Package riscv_mem_pkg holds:
  - the funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW);
  - the FSM state encoding (IDLE, REQ, WAIT, DONE);
  - a function returning the strobe from size and offset.
- One combinational sub-module, mem_load_align, takes response word, offset and funct3 and produces the extended 32-bit result.

Test Plan:
- Zero-wait LW at 0x100, rsp=0xDEADBEEF → Stall high for 2 cycles, then DONE with ReadData_out=0xDEADBEEF and Fault_out=0.
- LB at 0x103 then LBU at 0x103, rsp=0x80FF_1234 → ReadData_out=0xFFFFFF80, then 0x00000080.
- SH at 0x102, data 0x0000ABCD, ready held low 3 cycles → req_valid held 4 cycles, wstrb=1100, wdata=0xABCDABCD, address stable; DONE follows acceptance.
- LW at 0x101, then SB with MemRead and MemWrite both set, then funct3=011 → each gives Fault_out pulse with FaultAddr_out set and no req_valid.
- Load with no response for TIMEOUT=4 → Fault_out in cycle after 4 WAIT cycles and ReadData_out=0; also rsp_err=1 → same fault.
- reset=0 during WAIT → outputs cleared immediately; late rsp_valid after release ignored; next LW completes normally.
